// File: rtl/sum_accumulator.sv
// Accumulates the 5-bit {carry_out, sum} results of an upstream 4-bit adder into an
// ACC_W-bit total. Optional clamping on overflow is enabled with SUM_ACCUMULATOR_SATURATE_EN.
module sum_accumulator #(
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sum,
  input  logic             carry_out,
  input  logic             clear,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] count,
  output logic             acc_valid,
  output logic             overflow,
  output logic             full,
  output logic [1:0]       state_dbg
);

  // Handshake: a result transfers in a cycle where in_valid && in_ready at the rising
  // edge; in_ready is combinational and drops during rst, clear, or while FULL.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

  state_t           state, state_nx;
  logic             xfer;
  logic [ACC_W:0]   addend;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_next;

  assign in_ready = (state != FULL) && !clear && !rst;
  assign xfer     = in_valid && in_ready;
  assign addend   = {{(ACC_W-4){1'b0}}, carry_out, sum};
  assign acc_sum  = {1'b0, acc} + addend;

`ifdef SUM_ACCUMULATOR_SATURATE_EN
  // Once overflow is flagged the total stays pinned at full scale until cleared.
  assign acc_next = (overflow || acc_sum[ACC_W]) ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
`else
  assign acc_next = acc_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (xfer) state_nx = ACCUM;
        ACCUM:   if (xfer && (count == CNT_LAST)) state_nx = FULL;
        FULL:    state_nx = FULL;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    full      = (state == FULL);
    state_dbg = state;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc       <= '0;
      count     <= '0;
      acc_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      acc_valid <= xfer;
      if (xfer) begin
        acc   <= acc_next;
        count <= count + CNT_ONE;
        if (acc_sum[ACC_W]) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed and randomized checks of sum_accumulator against an arithmetic model of
// the running total (unbounded integer total, reduced to ACC_W bits on comparison).
module tb_sum_accumulator;
  localparam int ACC_W = 8;
  localparam int CNT_W = 4;
  localparam int ACC_MAX = (1 << ACC_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       sum = '0;
  logic             carry_out = 1'b0;
  logic             clear = 1'b0;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             acc_valid;
  logic             overflow;
  logic             full;
  logic [1:0]       state_dbg;

  sum_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .carry_out(carry_out), .clear(clear), .acc(acc), .count(count),
    .acc_valid(acc_valid), .overflow(overflow), .full(full), .state_dbg(state_dbg)
  );

  // reference model: total of all accepted addends since last reset/clear
  int total = 0;
  int cnt = 0;
  logic [ACC_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic int exp_acc();
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    return (total > ACC_MAX) ? ACC_MAX : total;
`else
    return total % (ACC_MAX + 1);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver: one clock cycle of stimulus followed by a full scoreboard check
  task automatic step(input bit v, input logic [4:0] a, input bit clr, input bit r);
    bit exp_rdy, xfer;
    logic [ACC_W-1:0] q_acc;
    @(negedge clk);
    in_valid = v;
    {carry_out, sum} = a;
    clear = clr;
    rst = r;
    #1;
    exp_rdy = !r && !clr && (cnt != CNT_MAX);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    xfer = v && exp_rdy;
    @(posedge clk);
    if (r || clr) begin
      total = 0;
      cnt = 0;
      exp_q.delete();
      xfer = 1'b0;
    end else if (xfer) begin
      total += int'(a);
      cnt++;
      exp_q.push_back(ACC_W'(exp_acc()));
    end
    #1;
    check("acc", 32'(acc), 32'(exp_acc()));
    check("count", 32'(count), 32'(cnt));
    check("acc_valid", {31'd0, acc_valid}, {31'd0, xfer});
    check("overflow", {31'd0, overflow}, {31'd0, (total > ACC_MAX)});
    check("full", {31'd0, full}, {31'd0, (cnt == CNT_MAX)});
    if (acc_valid) begin
      if (exp_q.size() == 0) check("queue_empty", 32'd1, 32'd0);
      else begin
        q_acc = exp_q.pop_front();
        check("acc_scoreboard", 32'(acc), 32'(q_acc));
      end
    end
  endtask

  task automatic idle_rand();
    step(1'b0, 5'($urandom_range(0, 31)), 1'b0, 1'b0);
  endtask

  initial begin
    // reset state
    step(1'b0, 5'h00, 1'b0, 1'b1);
    // single transfer after reset: 5'h13 -> 19
    step(1'b1, 5'h13, 1'b0, 1'b0);
    idle_rand();
    // back-to-back: 31, 62, 64
    step(1'b0, 5'h00, 1'b1, 1'b0);
    step(1'b1, 5'h1F, 1'b0, 1'b0);
    step(1'b1, 5'h1F, 1'b0, 1'b0);
    step(1'b1, 5'h02, 1'b0, 1'b0);
    check("b2b_acc", 32'(acc), 32'd64);
    // data while in_valid=0 must be ignored
    for (int i = 0; i < 3; i++) idle_rand();
    // wrap/saturate: 9 x 31 = 279
    step(1'b0, 5'h00, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 5'h1F, 1'b0, 1'b0);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    check("sat_acc", 32'(acc), 32'd255);
`else
    check("wrap_acc", 32'(acc), 32'd23);
`endif
    check("wrap_ovf", {31'd0, overflow}, 32'd1);
    // fill the counter: 15 x 1, then a 16th is refused
    step(1'b0, 5'h00, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, 5'h01, 1'b0, 1'b0);
    step(1'b1, 5'h01, 1'b0, 1'b0);
    check("full_acc", 32'(acc), 32'd15);
    // clear beats in_valid at acc=40
    step(1'b0, 5'h00, 1'b1, 1'b0);
    step(1'b1, 5'h14, 1'b0, 1'b0);
    step(1'b1, 5'h14, 1'b0, 1'b0);
    step(1'b1, 5'h05, 1'b1, 1'b0);
    check("clear_acc", 32'(acc), 32'd0);
    // reset on a transfer at count=7
    for (int i = 0; i < 7; i++) step(1'b1, 5'($urandom_range(0, 31)), 1'b0, 1'b0);
    step(1'b1, 5'h09, 1'b0, 1'b1);
    step(1'b1, 5'h03, 1'b0, 1'b0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
           $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter ACC_W, default 8, giving the accumulator width in bits; legal values are 6..16.
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the accepted-operation counter width in bits; legal values are 2..8.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock, with all state updated on the rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: the reset, which is synchronous and active-high.
REQ-005 Port in_valid SHALL be an input, 1 bit wide: the upstream adder result is valid.
REQ-006 Port in_ready SHALL be an output, 1 bit wide: the block can accept a result this cycle.
REQ-007 Port sum SHALL be an input, 4 bits wide: the 4-bit sum from the upstream 4-bit adder.
REQ-008 Port carry_out SHALL be an input, 1 bit wide: the carry from the upstream adder, forming bit 4 of the addend.
REQ-009 Port clear SHALL be an input, 1 bit wide: a synchronous request to zero the accumulator, counter and flags.
REQ-010 Port acc SHALL be an output, ACC_W bits wide: the running total.
REQ-011 Port count SHALL be an output, CNT_W bits wide: the number of results accepted since the last reset or clear.
REQ-012 Port acc_valid SHALL be an output, 1 bit wide: a one-cycle pulse indicating that acc was updated.
REQ-013 Port overflow SHALL be an output, 1 bit wide: a sticky flag indicating the accumulator exceeded its range.
REQ-014 Port full SHALL be an output, 1 bit wide: the counter is saturated and no further input is accepted.

Function
REQ-015 The addend SHALL be the 5-bit value {carry_out, sum}, zero-extended to ACC_W+1 bits.
REQ-016 A transfer SHALL occur only in a cycle where in_valid=1 and in_ready=1.
REQ-017 in_ready SHALL be combinational and equal to (state != FULL) && !clear.
REQ-018 On a transfer, acc SHALL be updated to acc+addend at the next rising edge, giving a latency of one cycle.
REQ-019 On a transfer, count SHALL increment by 1 at the same edge as acc.
REQ-020 On a transfer, acc_valid SHALL be 1 for exactly the following cycle; otherwise acc_valid SHALL be 0.
REQ-021 The FSM SHALL have three states: IDLE (count=0), ACCUM (0<count<max) and FULL (count = 2^CNT_W-1).
REQ-022 The FSM SHALL transition IDLE->ACCUM on a transfer.
REQ-023 The FSM SHALL transition ACCUM->FULL on the transfer that makes count = 2^CNT_W-1.
REQ-024 The FSM SHALL transition FULL->IDLE only on clear or rst.
REQ-025 full SHALL be 1 exactly when state is FULL; in FULL, in_valid SHALL be ignored and acc SHALL be held.
REQ-026 When the ACC_W+1-bit sum has its MSB set, overflow SHALL be set at the same edge and SHALL remain set until clear or rst.
REQ-027 On overflow without SATURATE_EN, acc SHALL take the low ACC_W bits of the sum (wrap-around).
REQ-028 When clear=1, at the next edge acc, count, overflow and acc_valid SHALL be 0 and the state SHALL be IDLE.
REQ-029 clear SHALL win over a simultaneous in_valid; that input is not accepted, because in_ready=0.
REQ-030 sum and carry_out SHALL be sampled only during a transfer; values present when in_valid=0 SHALL have no effect.
REQ-031 Holding in_valid=1 with unchanged data for N ready cycles SHALL produce N transfers; the upstream stage owns deduplication.

Reset
REQ-032 rst SHALL be sampled only on the rising edge of clk.
REQ-033 rst SHALL take priority over clear and over any transfer.
REQ-034 After reset, acc=0, count=0, acc_valid=0, overflow=0, full=0 and the state SHALL be IDLE.
REQ-035 While rst=1, in_ready SHALL be 0.
REQ-036 Asserting rst mid-accumulation SHALL discard the partial total, with no pulse on acc_valid.

Configuration
REQ-037 With the macro SUM_ACCUMULATOR_SATURATE_EN defined, on overflow acc SHALL clamp to 2^ACC_W-1 and hold there on further transfers until clear or rst; overflow SHALL still be set.
REQ-038 Without SUM_ACCUMULATOR_SATURATE_EN, acc SHALL wrap modulo 2^ACC_W, and no saturation logic SHALL be present.

Verification
REQ-039 Reset scenario: after rst for 1 cycle, apply in_valid with {carry_out,sum}=5'h13 -> one cycle later acc=19, count=1, acc_valid pulse of 1 cycle, full=0.
REQ-040 Back-to-back scenario: apply in_valid for 3 consecutive cycles with addends 5'h1F, 5'h1F, 5'h02 -> acc=31, then 62, then 64 on consecutive cycles, count=3, overflow=0.
REQ-041 Wrap/saturate scenario: with ACC_W=8, accumulate 9 transfers of 5'h1F (total 279) -> without the macro acc=23 and overflow=1; with SUM_ACCUMULATOR_SATURATE_EN acc=255 and overflow=1.
REQ-042 Full scenario: with CNT_W=4, apply 15 transfers of 5'h01 -> count=15, full=1, in_ready=0; a 16th in_valid leaves acc=15 unchanged.
REQ-043 Simultaneous event scenario: assert clear and in_valid (addend 5'h05) in the same cycle while acc=40 -> next cycle acc=0, count=0, acc_valid=0, and the input is not accepted.
REQ-044 Reset mid-operation scenario: assert rst in the same cycle as a transfer at count=7 -> next cycle all outputs are 0, state is IDLE, and in_ready=1 once rst falls.
